bar_level_counter: RTL and testbench

//  Push-button up/down level counter with LED bar-graph and 7-segment readout.

---
 rtl/bar_level_counter_if.sv | 34 +++
 rtl/bar_level_counter.sv | 250 +++++++++++++++++++++++++
 tb/tb_bar_level_counter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/bar_level_counter_if.sv
// bar_level_counter_if
//   Board-side user I/O bundle for the bar-graph level counter.
//   Buttons are raw active-low pins (asynchronous to clk); the display
//   signals are driven by the counter.
//   master : board / testbench side (drives buttons, observes display)
//   slave  : bar_level_counter side
//   btn_up_n, btn_dn_n, btn_clr_n : active-low push buttons
//   led    [N_LED]  : thermometer bar
//   level  [LVL_W]  : current level
//   seg    [7]      : active-low 7-seg pattern, gfedcba
//   at_max, at_min  : level at N_LED / at 0
interface bar_level_counter_if #(
  parameter int N_LED = 8,
  parameter int LVL_W = 4
);
  logic             btn_up_n;
  logic             btn_dn_n;
  logic             btn_clr_n;
  logic [N_LED-1:0] led;
  logic [LVL_W-1:0] level;
  logic [6:0]       seg;
  logic             at_max;
  logic             at_min;

  modport master (
    output btn_up_n, btn_dn_n, btn_clr_n,
    input  led, level, seg, at_max, at_min
  );

  modport slave (
    input  btn_up_n, btn_dn_n, btn_clr_n,
    output led, level, seg, at_max, at_min
  );
endinterface

// File: rtl/bar_level_counter.sv
// bar_level_counter
//   Push-button up/down level counter with LED bar-graph and hex 7-seg readout.
//   Each button passes through a 2-flop synchroniser and a debouncer; up and
//   down each drive a hold-to-auto-repeat FSM that emits one-cycle step pulses.
//   Clear (held low) forces the level to 0 and overrides steps.
//   Ports:
//     clk : system clock
//     rst : asynchronous reset, active-high
//     io  : bar_level_counter_if.slave (buttons in, led/level/seg/at_max/at_min out)

// ---------------------------------------------------------------------------
// btn_debounce : synchroniser + debouncer for one active-low button.
//   o_stable is the accepted (debounced) level, released = 1.
//   A change is accepted on the sample after DEB_CYCLES consecutive
//   mismatching samples, so a clean fall sampled at edge 0 shows as
//   stable low after edge 2+DEB_CYCLES.
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_n,
  output logic o_stable
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_stable) begin
        // counter saturated at DEB_CYCLES and still different: accept
        if (r_cnt == CW'(DEB_CYCLES)) begin
          r_stable <= r_sync2;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_stable = r_stable;
endmodule

// ---------------------------------------------------------------------------
// btn_repeat : press detect + hold-to-auto-repeat FSM for one button.
//   i_stable : debounced button (active-low)
//   o_step   : one-cycle step pulse (first step on the press cycle itself)
// ---------------------------------------------------------------------------
module btn_repeat #(
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_stable,
  output logic o_step
);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_nxt;
  logic          r_stable_d;
  logic          w_press;
  logic          w_held;

  assign w_press = r_stable_d & ~i_stable;
  assign w_held  = ~i_stable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_stable_d <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_stable_d <= i_stable;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    o_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_press) begin
          o_step      = 1'b1;
          w_state_nxt = S_DELAY;
          w_timer_nxt = '0;
        end
      end
      S_DELAY: begin
        if (!w_held) begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
        end else if (r_timer == TW'(REPEAT_DELAY - 1)) begin
          o_step      = 1'b1;
          w_state_nxt = S_REPEAT;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      S_REPEAT: begin
        if (!w_held) begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
        end else if (r_timer == TW'(REPEAT_RATE - 1)) begin
          o_step      = 1'b1;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = '0;
      end
    endcase
  end
endmodule

// ---------------------------------------------------------------------------
// bar_level_counter : top
// ---------------------------------------------------------------------------
module bar_level_counter #(
  parameter int N_LED        = 8,
  parameter int LVL_W        = 4,
  parameter int DEB_CYCLES   = 4,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 4,
  parameter int WRAP         = 0
) (
  input  logic             clk,
  input  logic             rst,
  bar_level_counter_if.slave io
);
  localparam logic [LVL_W-1:0] L_MAX = LVL_W'(N_LED);

  // button lanes: 0 = up, 1 = dn, 2 = clr
  logic [2:0]       w_btn_n;
  logic [2:0]       w_stable;
  logic [1:0]       w_step;
  logic [LVL_W-1:0] r_level;
  logic [N_LED-1:0] w_led;
  logic [3:0]       w_nib;
  logic [6:0]       w_seg;

  assign w_btn_n = {io.btn_clr_n, io.btn_dn_n, io.btn_up_n};

  for (genvar g = 0; g < 3; g++) begin : g_deb
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk      (clk),
      .rst      (rst),
      .i_btn_n  (w_btn_n[g]),
      .o_stable (w_stable[g])
    );
  end

  // Only up/dn repeat; clear is level-sensitive.
  for (genvar g = 0; g < 2; g++) begin : g_rep
    btn_repeat #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_rep (
      .clk      (clk),
      .rst      (rst),
      .i_stable (w_stable[g]),
      .o_step   (w_step[g])
    );
  end

  // Clear wins; FSMs keep running so a held up/dn resumes after clear release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= '0;
    end else if (!w_stable[2]) begin
      r_level <= '0;
    end else if (w_step[0] && w_step[1]) begin
      r_level <= r_level;
    end else if (w_step[0]) begin
      if (r_level == L_MAX) r_level <= (WRAP != 0) ? '0 : L_MAX;
      else                  r_level <= r_level + 1'b1;
    end else if (w_step[1]) begin
      if (r_level == '0) r_level <= (WRAP != 0) ? L_MAX : '0;
      else               r_level <= r_level - 1'b1;
    end
  end

  for (genvar g = 0; g < N_LED; g++) begin : g_led
    assign w_led[g] = (r_level > LVL_W'(g));
  end

  if (LVL_W >= 4) begin : g_nib_wide
    assign w_nib = r_level[3:0];
  end else begin : g_nib_narrow
    assign w_nib = {{(4 - LVL_W){1'b0}}, r_level};
  end

  // active-low gfedcba hex decoder
  always_comb begin
    w_seg = 7'b1111111;
    case (w_nib)
      4'h0: w_seg = 7'b1000000;
      4'h1: w_seg = 7'b1111001;
      4'h2: w_seg = 7'b0100100;
      4'h3: w_seg = 7'b0110000;
      4'h4: w_seg = 7'b0011001;
      4'h5: w_seg = 7'b0010010;
      4'h6: w_seg = 7'b0000010;
      4'h7: w_seg = 7'b1111000;
      4'h8: w_seg = 7'b0000000;
      4'h9: w_seg = 7'b0010000;
      4'hA: w_seg = 7'b0001000;
      4'hB: w_seg = 7'b0000011;
      4'hC: w_seg = 7'b1000110;
      4'hD: w_seg = 7'b0100001;
      4'hE: w_seg = 7'b0000110;
      4'hF: w_seg = 7'b0001110;
      default: w_seg = 7'b1111111;
    endcase
  end

  assign io.level  = r_level;
  assign io.led    = w_led;
  assign io.seg    = w_seg;
  assign io.at_max = (r_level == L_MAX);
  assign io.at_min = (r_level == '0);
endmodule

// File: tb/tb_bar_level_counter.sv
// tb_bar_level_counter
//   Directed bench: two counters (saturating ifa/u_dut_a, wrapping ifb/u_dut_b).
//   "Edge 0" is the first posedge that samples a newly driven button value;
//   inputs change and outputs are sampled on negedges.
module tb_bar_level_counter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bar_level_counter_if #(.N_LED(8), .LVL_W(4)) ifa ();
  bar_level_counter_if #(.N_LED(8), .LVL_W(4)) ifb ();

  bar_level_counter #(
    .N_LED(8), .LVL_W(4), .DEB_CYCLES(4), .REPEAT_DELAY(16), .REPEAT_RATE(4), .WRAP(0)
  ) u_dut_a (.clk(clk), .rst(rst), .io(ifa));

  bar_level_counter #(
    .N_LED(8), .LVL_W(4), .DEB_CYCLES(4), .REPEAT_DELAY(16), .REPEAT_RATE(4), .WRAP(1)
  ) u_dut_b (.clk(clk), .rst(rst), .io(ifb));

  // wait until the negedge following posedge number e
  task automatic at_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  // 0..2 = a up/dn/clr, 3..5 = b up/dn/clr
  task automatic set_btn(input int sel, input logic v);
    case (sel)
      0: ifa.btn_up_n  = v;
      1: ifa.btn_dn_n  = v;
      2: ifa.btn_clr_n = v;
      3: ifb.btn_up_n  = v;
      4: ifb.btn_dn_n  = v;
      default: ifb.btn_clr_n = v;
    endcase
  endtask

  // short press (8 low samples), then idle long enough for the FSM to return to IDLE
  task automatic tap(input int sel);
    int e0;
    set_btn(sel, 1'b0);
    e0 = cyc + 1;
    at_edge(e0 + 7);
    set_btn(sel, 1'b1);
    at_edge(e0 + 30);
  endtask

  task automatic test_reset;
    n_tests++; if (ifa.level !== 4'd0) begin n_fail++; $display("FAIL rst_level: got %0d exp 0", ifa.level); end
    n_tests++; if (ifa.led !== 8'h00) begin n_fail++; $display("FAIL rst_led: got %h exp 00", ifa.led); end
    n_tests++; if (ifa.seg !== 7'b1000000) begin n_fail++; $display("FAIL rst_seg: got %b exp 1000000", ifa.seg); end
    n_tests++; if (ifa.at_min !== 1'b1) begin n_fail++; $display("FAIL rst_at_min: got %b exp 1", ifa.at_min); end
    n_tests++; if (ifa.at_max !== 1'b0) begin n_fail++; $display("FAIL rst_at_max: got %b exp 0", ifa.at_max); end
  endtask

  task automatic test_press_latency;
    int e0;
    set_btn(0, 1'b0);
    e0 = cyc + 1;
    at_edge(e0 + 6);
    n_tests++; if (ifa.level !== 4'd0) begin n_fail++; $display("FAIL lat_edge6: got %0d exp 0", ifa.level); end
    at_edge(e0 + 7);
    n_tests++; if (ifa.level !== 4'd1) begin n_fail++; $display("FAIL lat_edge7: got %0d exp 1", ifa.level); end
    n_tests++; if (ifa.led !== 8'h01) begin n_fail++; $display("FAIL lat_led: got %h exp 01", ifa.led); end
    n_tests++; if (ifa.seg !== 7'b1111001) begin n_fail++; $display("FAIL lat_seg: got %b exp 1111001", ifa.seg); end
    at_edge(e0 + 9);
    set_btn(0, 1'b1);
    at_edge(e0 + 30);
    n_tests++; if (ifa.level !== 4'd1) begin n_fail++; $display("FAIL lat_one_step: got %0d exp 1", ifa.level); end
  endtask

  task automatic test_bounce;
    int es;
    for (int i = 0; i < 20; i++) begin
      set_btn(0, 1'b0);
      repeat ((i % 3) + 1) @(negedge clk);
      set_btn(0, 1'b1);
      repeat (5) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    n_tests++; if (ifa.level !== 4'd1) begin n_fail++; $display("FAIL bounce_reject: got %0d exp 1", ifa.level); end
    // 3-cycle glitch, 2 high, then steady low
    set_btn(0, 1'b0);
    repeat (3) @(negedge clk);
    set_btn(0, 1'b1);
    repeat (2) @(negedge clk);
    set_btn(0, 1'b0);
    es = cyc + 1;
    at_edge(es + 6);
    n_tests++; if (ifa.level !== 4'd1) begin n_fail++; $display("FAIL bounce_pre: got %0d exp 1", ifa.level); end
    at_edge(es + 7);
    n_tests++; if (ifa.level !== 4'd2) begin n_fail++; $display("FAIL bounce_step: got %0d exp 2", ifa.level); end
    at_edge(es + 11);
    set_btn(0, 1'b1);
    at_edge(es + 30);
    n_tests++; if (ifa.level !== 4'd2) begin n_fail++; $display("FAIL bounce_once: got %0d exp 2", ifa.level); end
  endtask

  task automatic test_auto_repeat;
    int e0;
    tap(2);
    n_tests++; if (ifa.level !== 4'd0) begin n_fail++; $display("FAIL clr_tap: got %0d exp 0", ifa.level); end
    set_btn(0, 1'b0);
    e0 = cyc + 1;
    at_edge(e0 + 7);
    n_tests++; if (ifa.level !== 4'd1) begin n_fail++; $display("FAIL rep_first: got %0d exp 1", ifa.level); end
    at_edge(e0 + 22);
    n_tests++; if (ifa.level !== 4'd1) begin n_fail++; $display("FAIL rep_delay_hold: got %0d exp 1", ifa.level); end
    at_edge(e0 + 23);
    n_tests++; if (ifa.level !== 4'd2) begin n_fail++; $display("FAIL rep_plus16: got %0d exp 2", ifa.level); end
    at_edge(e0 + 26);
    n_tests++; if (ifa.level !== 4'd2) begin n_fail++; $display("FAIL rep_rate_hold: got %0d exp 2", ifa.level); end
    at_edge(e0 + 27);
    n_tests++; if (ifa.level !== 4'd3) begin n_fail++; $display("FAIL rep_plus20: got %0d exp 3", ifa.level); end
    at_edge(e0 + 39);
    set_btn(0, 1'b1);
    at_edge(e0 + 42);
    n_tests++; if (ifa.level !== 4'd6) begin n_fail++; $display("FAIL rep_plus32: got %0d exp 6", ifa.level); end
    at_edge(e0 + 43);
    n_tests++; if (ifa.level !== 4'd7) begin n_fail++; $display("FAIL rep_plus36: got %0d exp 7", ifa.level); end
    at_edge(e0 + 60);
    n_tests++; if (ifa.level !== 4'd7) begin n_fail++; $display("FAIL rep_release: got %0d exp 7", ifa.level); end
    n_tests++; if (ifa.led !== 8'h7f) begin n_fail++; $display("FAIL rep_led: got %h exp 7f", ifa.led); end
  endtask

  task automatic test_boundaries;
    tap(0);
    n_tests++; if (ifa.level !== 4'd8) begin n_fail++; $display("FAIL bnd_to_max: got %0d exp 8", ifa.level); end
    n_tests++; if (ifa.led !== 8'hff) begin n_fail++; $display("FAIL bnd_led: got %h exp ff", ifa.led); end
    n_tests++; if (ifa.seg !== 7'b0000000) begin n_fail++; $display("FAIL bnd_seg: got %b exp 0000000", ifa.seg); end
    tap(0);
    n_tests++; if (ifa.level !== 4'd8) begin n_fail++; $display("FAIL bnd_sat: got %0d exp 8", ifa.level); end
    n_tests++; if (ifa.at_max !== 1'b1) begin n_fail++; $display("FAIL bnd_at_max: got %b exp 1", ifa.at_max); end
    n_tests++; if (ifb.level !== 4'd0) begin n_fail++; $display("FAIL wrap_init: got %0d exp 0", ifb.level); end
    tap(4);
    n_tests++; if (ifb.level !== 4'd8) begin n_fail++; $display("FAIL wrap_dn: got %0d exp 8", ifb.level); end
    tap(3);
    n_tests++; if (ifb.level !== 4'd0) begin n_fail++; $display("FAIL wrap_up: got %0d exp 0", ifb.level); end
    n_tests++; if (ifb.at_min !== 1'b1) begin n_fail++; $display("FAIL wrap_at_min: got %b exp 1", ifb.at_min); end
  endtask

  task automatic test_simultaneous;
    int e0;
    set_btn(0, 1'b0);
    set_btn(1, 1'b0);
    e0 = cyc + 1;
    at_edge(e0 + 7);
    n_tests++; if (ifa.level !== 4'd8) begin n_fail++; $display("FAIL simul_step: got %0d exp 8", ifa.level); end
    set_btn(0, 1'b1);
    set_btn(1, 1'b1);
    at_edge(e0 + 30);
    n_tests++; if (ifa.level !== 4'd8) begin n_fail++; $display("FAIL simul_after: got %0d exp 8", ifa.level); end
  endtask

  task automatic test_clear_hold;
    int e0;
    set_btn(0, 1'b0);
    e0 = cyc + 1;
    at_edge(e0 + 7);
    n_tests++; if (ifa.at_max !== 1'b1) begin n_fail++; $display("FAIL clrh_sat: got %b exp 1", ifa.at_max); end
    at_edge(e0 + 9);
    set_btn(2, 1'b0);
    at_edge(e0 + 16);
    n_tests++; if (ifa.level !== 4'd8) begin n_fail++; $display("FAIL clrh_pre: got %0d exp 8", ifa.level); end
    at_edge(e0 + 17);
    n_tests++; if (ifa.level !== 4'd0) begin n_fail++; $display("FAIL clrh_clear: got %0d exp 0", ifa.level); end
    at_edge(e0 + 24);
    n_tests++; if (ifa.level !== 4'd0) begin n_fail++; $display("FAIL clrh_rep1: got %0d exp 0", ifa.level); end
    at_edge(e0 + 32);
    n_tests++; if (ifa.level !== 4'd0) begin n_fail++; $display("FAIL clrh_rep3: got %0d exp 0", ifa.level); end
    set_btn(2, 1'b1);
    at_edge(e0 + 42);
    n_tests++; if (ifa.level !== 4'd0) begin n_fail++; $display("FAIL clrh_rel_pre: got %0d exp 0", ifa.level); end
    at_edge(e0 + 43);
    n_tests++; if (ifa.level !== 4'd1) begin n_fail++; $display("FAIL clrh_rel_step: got %0d exp 1", ifa.level); end
    set_btn(0, 1'b1);
    at_edge(e0 + 60);
    n_tests++; if (ifa.level !== 4'd2) begin n_fail++; $display("FAIL clrh_final: got %0d exp 2", ifa.level); end
  endtask

  task automatic test_reset_midhold;
    int e0;
    set_btn(0, 1'b0);
    e0 = cyc + 1;
    at_edge(e0 + 7);
    n_tests++; if (ifa.level !== 4'd3) begin n_fail++; $display("FAIL rmh_step: got %0d exp 3", ifa.level); end
    at_edge(e0 + 12);
    rst = 1'b1;
    #1;
    n_tests++; if (ifa.level !== 4'd0) begin n_fail++; $display("FAIL rmh_level: got %0d exp 0", ifa.level); end
    n_tests++; if (ifa.led !== 8'h00) begin n_fail++; $display("FAIL rmh_led: got %h exp 00", ifa.led); end
    n_tests++; if (ifa.seg !== 7'b1000000) begin n_fail++; $display("FAIL rmh_seg: got %b exp 1000000", ifa.seg); end
    n_tests++; if (ifa.at_min !== 1'b1) begin n_fail++; $display("FAIL rmh_at_min: got %b exp 1", ifa.at_min); end
    at_edge(e0 + 14);
    rst = 1'b0;
    at_edge(e0 + 21);
    n_tests++; if (ifa.level !== 4'd0) begin n_fail++; $display("FAIL rmh_redeb: got %0d exp 0", ifa.level); end
    at_edge(e0 + 22);
    n_tests++; if (ifa.level !== 4'd1) begin n_fail++; $display("FAIL rmh_fresh: got %0d exp 1", ifa.level); end
    set_btn(0, 1'b1);
    at_edge(e0 + 40);
  endtask

  initial begin
    ifa.btn_up_n = 1'b1; ifa.btn_dn_n = 1'b1; ifa.btn_clr_n = 1'b1;
    ifb.btn_up_n = 1'b1; ifb.btn_dn_n = 1'b1; ifb.btn_clr_n = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset;
    test_press_latency;
    test_bounce;
    test_auto_repeat;
    test_boundaries;
    test_simultaneous;
    test_clear_hold;
    test_reset_midhold;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
